// File: rtl/uart_baud_gen_p.sv
// ---------------------------------------------------------------------------
// uart_baud_gen_p
//   Parametrised UART baud tick generator. It produces a 1x bit tick for the
//   transmitter and an OVERSAMPLE-x sample tick plus a sample index for the
//   receiver. The rate is picked from an 8-entry table or taken from a
//   runtime custom divisor. While running, a new rate is only adopted on a
//   bit boundary, so a bit in flight is never shortened or stretched. RX_SYNC
//   re-phases the receive counter on a start-bit edge.
//
// Ports
//   CLK         in   clock, rising edge
//   RST_N       in   asynchronous active-low reset
//   EN          in   run enable; low holds counters, ticks and index at 0
//   BD_SEL      in   table select 1200..115200 baud (0..7)
//   USE_CUSTOM  in   1: use DIV_CUSTOM instead of the table
//   DIV_CUSTOM  in   custom TX divisor in clocks per bit
//   RX_SYNC     in   single-cycle start-bit pulse; restarts the RX phase
//   BDCLK       out  single-cycle TX bit tick
//   BDSAM       out  single-cycle RX sample tick
//   SAM_IDX     out  index of the most recent BDSAM within the bit
//   RATE_PEND   out  requested rate differs from the active rate
// ---------------------------------------------------------------------------
module uart_baud_gen_p #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 16,
  parameter logic [2:0]  RESET_SEL  = 3'd3
) (
  input  logic                            CLK,
  input  logic                            RST_N,
  input  logic                            EN,
  input  logic [2:0]                      BD_SEL,
  input  logic                            USE_CUSTOM,
  input  logic [CNT_W-1:0]                DIV_CUSTOM,
  input  logic                            RX_SYNC,
  output logic                            BDCLK,
  output logic                            BDSAM,
  output logic [$clog2(OVERSAMPLE)-1:0]   SAM_IDX,
  output logic                            RATE_PEND
);

  localparam int IDX_W = $clog2(OVERSAMPLE);

  // Integer-truncated divisor; a result of 0 is promoted to 1 so the
  // counter still produces a tick every enabled cycle.
  function automatic logic [CNT_W-1:0] div_of(input int unsigned num,
                                               input int unsigned den);
    int unsigned q;
    q = num / den;
    if (q == 0) q = 1;
    return q[CNT_W-1:0];
  endfunction

  localparam logic [CNT_W-1:0] TX_TAB [8] = '{
    div_of(CLK_HZ, 1200),   div_of(CLK_HZ, 2400),   div_of(CLK_HZ, 4800),
    div_of(CLK_HZ, 9600),   div_of(CLK_HZ, 19200),  div_of(CLK_HZ, 38400),
    div_of(CLK_HZ, 57600),  div_of(CLK_HZ, 115200)
  };

  localparam logic [CNT_W-1:0] RX_TAB [8] = '{
    div_of(CLK_HZ, 1200 * OVERSAMPLE),   div_of(CLK_HZ, 2400 * OVERSAMPLE),
    div_of(CLK_HZ, 4800 * OVERSAMPLE),   div_of(CLK_HZ, 9600 * OVERSAMPLE),
    div_of(CLK_HZ, 19200 * OVERSAMPLE),  div_of(CLK_HZ, 38400 * OVERSAMPLE),
    div_of(CLK_HZ, 57600 * OVERSAMPLE),  div_of(CLK_HZ, 115200 * OVERSAMPLE)
  };

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] tx_c_q, tx_c_d;
  logic [CNT_W-1:0] rx_c_q, rx_c_d;
  logic [CNT_W-1:0] tx_div_q, tx_div_d;
  logic [CNT_W-1:0] rx_div_q, rx_div_d;
  logic             bdclk_q, bdclk_d;
  logic             bdsam_q, bdsam_d;
  logic [IDX_W-1:0] sam_idx_q, sam_idx_d;
  logic             rate_pend_q, rate_pend_d;

  logic [CNT_W-1:0] req_tx, req_rx, cust_rx;
  logic             tx_wrap, rx_wrap, differ, apply;

  // Requested divisors, re-evaluated every cycle.
  always_comb begin
    cust_rx = DIV_CUSTOM >> IDX_W;
    req_tx  = TX_TAB[BD_SEL];
    req_rx  = RX_TAB[BD_SEL];
    if (USE_CUSTOM) begin
      req_tx = (DIV_CUSTOM == CNT_ZERO) ? CNT_ONE : DIV_CUSTOM;
      req_rx = (cust_rx == CNT_ZERO) ? CNT_ONE : cust_rx;
    end
  end

  always_comb begin
    tx_wrap = (tx_c_q == tx_div_q - CNT_ONE);
    rx_wrap = (rx_c_q == rx_div_q - CNT_ONE);
    differ  = (req_tx != tx_div_q) || (req_rx != rx_div_q);
    // A new rate is only taken at the end of a bit; the clear of both
    // counters lines the new RX phase up with the new bit.
    apply   = EN && tx_wrap && differ;

    tx_c_d    = tx_c_q;
    rx_c_d    = rx_c_q;
    tx_div_d  = tx_div_q;
    rx_div_d  = rx_div_q;
    bdclk_d   = 1'b0;
    bdsam_d   = 1'b0;
    sam_idx_d = sam_idx_q;

    if (!EN) begin
      // Idle: track the request directly so nothing is ever pending.
      tx_c_d    = CNT_ZERO;
      rx_c_d    = CNT_ZERO;
      sam_idx_d = '0;
      tx_div_d  = req_tx;
      rx_div_d  = req_rx;
    end else begin
      tx_c_d  = tx_wrap ? CNT_ZERO : tx_c_q + CNT_ONE;
      bdclk_d = tx_wrap;
      if (apply) begin
        // Also covers RX_SYNC on the same edge: a single clear.
        tx_div_d  = req_tx;
        rx_div_d  = req_rx;
        rx_c_d    = CNT_ZERO;
        sam_idx_d = '0;
      end else if (RX_SYNC) begin
        // Start-bit re-phase wins over a coincident sample wrap.
        rx_c_d    = CNT_ZERO;
        sam_idx_d = '0;
      end else if (rx_wrap) begin
        rx_c_d    = CNT_ZERO;
        bdsam_d   = 1'b1;
        sam_idx_d = sam_idx_q + IDX_ONE;
      end else begin
        rx_c_d = rx_c_q + CNT_ONE;
      end
    end

    rate_pend_d = (req_tx != tx_div_d) || (req_rx != rx_div_d);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_c_q      <= CNT_ZERO;
      rx_c_q      <= CNT_ZERO;
      tx_div_q    <= TX_TAB[RESET_SEL];
      rx_div_q    <= RX_TAB[RESET_SEL];
      bdclk_q     <= 1'b0;
      bdsam_q     <= 1'b0;
      sam_idx_q   <= '0;
      rate_pend_q <= 1'b0;
    end else begin
      tx_c_q      <= tx_c_d;
      rx_c_q      <= rx_c_d;
      tx_div_q    <= tx_div_d;
      rx_div_q    <= rx_div_d;
      bdclk_q     <= bdclk_d;
      bdsam_q     <= bdsam_d;
      sam_idx_q   <= sam_idx_d;
      rate_pend_q <= rate_pend_d;
    end
  end

  assign BDCLK     = bdclk_q;
  assign BDSAM     = bdsam_q;
  assign SAM_IDX   = sam_idx_q;
  assign RATE_PEND = rate_pend_q;

endmodule

// File: tb/tb_uart_baud_gen_p.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_gen_p
//   Directed and randomized bench for uart_baud_gen_p. A reference model
//   describes tick timing as phase anchors plus modulo arithmetic on the
//   edge count; every cycle the DUT outputs are compared against it, and
//   the documented timing points are compared against constants.
// ---------------------------------------------------------------------------
module tb_uart_baud_gen_p;

  localparam int CLK_HZ = 50_000_000;
  localparam int OS     = 16;
  localparam int CNT_W  = 16;
  localparam int IDX_W  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic             CLK = 1'b0;
  logic             RST_N;
  logic             EN;
  logic [2:0]       BD_SEL;
  logic             USE_CUSTOM;
  logic [CNT_W-1:0] DIV_CUSTOM;
  logic             RX_SYNC;
  logic             BDCLK;
  logic             BDSAM;
  logic [IDX_W-1:0] SAM_IDX;
  logic             RATE_PEND;

  always #5 CLK = ~CLK;

  uart_baud_gen_p #(
    .CLK_HZ    (CLK_HZ),
    .OVERSAMPLE(OS),
    .CNT_W     (CNT_W),
    .RESET_SEL (3'd3)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .BD_SEL    (BD_SEL),
    .USE_CUSTOM(USE_CUSTOM),
    .DIV_CUSTOM(DIV_CUSTOM),
    .RX_SYNC   (RX_SYNC),
    .BDCLK     (BDCLK),
    .BDSAM     (BDSAM),
    .SAM_IDX   (SAM_IDX),
    .RATE_PEND (RATE_PEND)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int assert_cnt = 0;
  int fail_cnt   = 0;
  logic [IDX_W-1:0] exp_q[$];
  int sam_prev_n  = -1;
  int sam_per_exp = 0;

  // ---------------- reference model ----------------
  int n = 0;
  int m_txd, m_rxd, m_ta, m_ra, m_idx;
  bit m_bdclk, m_bdsam, m_pend;

  function automatic int rate_of(input int sel);
    case (sel)
      0: return 1200;
      1: return 2400;
      2: return 4800;
      3: return 9600;
      4: return 19200;
      5: return 38400;
      6: return 57600;
      default: return 115200;
    endcase
  endfunction

  function automatic int req_tx();
    int q;
    if (USE_CUSTOM) q = int'(DIV_CUSTOM);
    else q = CLK_HZ / rate_of(int'(BD_SEL));
    return (q == 0) ? 1 : q;
  endfunction

  function automatic int req_rx();
    int q;
    if (USE_CUSTOM) q = int'(DIV_CUSTOM) / OS;
    else q = CLK_HZ / (rate_of(int'(BD_SEL)) * OS);
    return (q == 0) ? 1 : q;
  endfunction

  task automatic model_reset();
    m_txd = CLK_HZ / 9600;
    m_rxd = CLK_HZ / (9600 * OS);
    m_ta = n;
    m_ra = n;
    m_idx = 0;
    m_bdclk = 0;
    m_bdsam = 0;
    m_pend = 0;
  endtask

  // Ticks fall on edges that are a whole number of periods after the
  // latest phase anchor (the edge after which a count restarted from 0).
  task automatic model_edge();
    int rt, rr;
    bit txw, rxw;
    n++;
    if (!RST_N) begin
      m_ta = n;
      m_ra = n;
      return;
    end
    rt = req_tx();
    rr = req_rx();
    if (!EN) begin
      m_txd = rt;
      m_rxd = rr;
      m_ta = n;
      m_ra = n;
      m_idx = 0;
      m_bdclk = 0;
      m_bdsam = 0;
    end else begin
      txw = ((n - m_ta) % m_txd) == 0;
      rxw = ((n - m_ra) % m_rxd) == 0;
      m_bdclk = txw;
      m_bdsam = 0;
      if (txw && (rt != m_txd || rr != m_rxd)) begin
        m_txd = rt;
        m_rxd = rr;
        m_ta = n;
        m_ra = n;
        m_idx = 0;
      end else if (RX_SYNC) begin
        m_ra = n;
        m_idx = 0;
      end else if (rxw) begin
        m_bdsam = 1;
        m_idx = (m_idx + 1) % OS;
      end
    end
    m_pend = (rt != m_txd) || (rr != m_rxd);
  endtask

  // ---------------- checking and driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("bdclk", 32'(BDCLK), 32'(m_bdclk));
    chk("bdsam", 32'(BDSAM), 32'(m_bdsam));
    chk("sam_idx", 32'(SAM_IDX), 32'(m_idx));
    chk("rate_pend", 32'(RATE_PEND), 32'(m_pend));
    if (BDSAM === 1'b1) begin
      if (sam_per_exp != 0 && sam_prev_n >= 0)
        chk("sam_period", 32'(n - sam_prev_n), 32'(sam_per_exp));
      sam_prev_n = n;
      if (exp_q.size() > 0)
        chk("sam_idx_seq", 32'(SAM_IDX), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_tick(input bit sam, input int limit, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (((sam ? BDSAM : BDCLK) !== 1'b1) && cyc < limit);
    chk(sam ? "bdsam_seen" : "bdclk_seen", 32'(sam ? BDSAM : BDCLK), 32'd1);
  endtask

  task automatic restart(input bit cust, input int sel, input int dc);
    EN = 1'b0;
    step();
    USE_CUSTOM = cust;
    BD_SEL = 3'(sel);
    DIV_CUSTOM = 16'(dc);
    step();
    EN = 1'b1;
    sam_prev_n = -1;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int c, c2, c3;
    RST_N = 1'b0;
    EN = 1'b0;
    BD_SEL = 3'd3;
    USE_CUSTOM = 1'b0;
    DIV_CUSTOM = '0;
    RX_SYNC = 1'b0;
    model_reset();
    #2;
    chk("reset_bdclk", 32'(BDCLK), 0);
    chk("reset_bdsam", 32'(BDSAM), 0);
    chk("reset_sam_idx", 32'(SAM_IDX), 0);
    chk("reset_rate_pend", 32'(RATE_PEND), 0);
    repeat (4) step();
    RST_N = 1'b1;
    step();

    // 9600 baud: bit period, sample period, index wrap
    for (int i = 0; i < 32; i++) exp_q.push_back(IDX_W'((i + 1) % OS));
    sam_per_exp = 325;
    restart(0, 3, 0);
    wait_tick(0, 6000, c);
    chk("t1_first_bdclk", 32'(c), 5208);
    wait_tick(0, 6000, c);
    chk("t1_bdclk_period", 32'(c), 5208);
    chk("t1_sam_seq_done", 32'(exp_q.size()), 0);

    // 115200 and 1200 table entries
    sam_per_exp = 27;
    restart(0, 7, 0);
    wait_tick(0, 1000, c);
    chk("t2_sel7_first", 32'(c), 434);
    wait_tick(0, 1000, c);
    chk("t2_sel7_period", 32'(c), 434);
    sam_per_exp = 0;
    restart(0, 0, 0);
    wait_tick(1, 3000, c);
    chk("t2_sel0_first_bdsam", 32'(c), 2604);
    wait_tick(0, 45000, c2);
    chk("t2_sel0_first_bdclk", 32'(c + c2), 41666);

    // rate change mid-bit is deferred to the bit boundary
    restart(0, 3, 0);
    repeat (1000) step();
    BD_SEL = 3'd7;
    step();
    chk("t3_pend_set", 32'(RATE_PEND), 1);
    wait_tick(0, 6000, c);
    chk("t3_old_period", 32'(1001 + c), 5208);
    chk("t3_pend_clear", 32'(RATE_PEND), 0);
    wait_tick(0, 1000, c);
    chk("t3_new_period", 32'(c), 434);

    // custom divisor, including 0
    sam_per_exp = 6;
    restart(1, 0, 100);
    wait_tick(0, 200, c);
    chk("t4_custom_first", 32'(c), 100);
    wait_tick(0, 200, c);
    chk("t4_custom_period", 32'(c), 100);
    sam_per_exp = 1;
    restart(1, 0, 0);
    repeat (3) begin
      step();
      chk("t4_div0_bdclk", 32'(BDCLK), 1);
      chk("t4_div0_bdsam", 32'(BDSAM), 1);
    end

    // RX re-phase leaves the TX bit timing alone
    sam_per_exp = 0;
    restart(0, 3, 0);
    wait_tick(1, 400, c);
    chk("t5_first_bdsam", 32'(c), 325);
    repeat (200) step();
    RX_SYNC = 1'b1;
    step();
    RX_SYNC = 1'b0;
    wait_tick(1, 400, c2);
    chk("t5_sync_sam_delay", 32'(c2), 325);
    chk("t5_sync_idx", 32'(SAM_IDX), 1);
    wait_tick(0, 6000, c3);
    chk("t5_bdclk_unchanged", 32'(325 + 200 + 1 + c2 + c3), 5208);

    // reset mid-period, then EN drop
    restart(0, 3, 0);
    repeat (777) step();
    BD_SEL = 3'd7;
    step();
    RST_N = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_bdclk", 32'(BDCLK), 0);
    chk("t6_rst_bdsam", 32'(BDSAM), 0);
    chk("t6_rst_sam_idx", 32'(SAM_IDX), 0);
    chk("t6_rst_rate_pend", 32'(RATE_PEND), 0);
    BD_SEL = 3'd3;
    repeat (5) step();
    RST_N = 1'b1;
    sam_prev_n = -1;
    wait_tick(0, 6000, c);
    chk("t6_first_bdclk_after_rst", 32'(c), 5208);
    repeat (400) step();
    EN = 1'b0;
    step();
    chk("t6_en_off_bdclk", 32'(BDCLK), 0);
    chk("t6_en_off_bdsam", 32'(BDSAM), 0);
    chk("t6_en_off_sam_idx", 32'(SAM_IDX), 0);

    // randomized rate changes, syncs and enable toggles
    EN = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        USE_CUSTOM = 1'($urandom_range(0, 1));
        BD_SEL = 3'($urandom_range(4, 7));
        DIV_CUSTOM = 16'($urandom_range(0, 300));
      end
      if ($urandom_range(0, 499) == 0) EN = ~EN;
      RX_SYNC = ($urandom_range(0, 49) == 0);
      step();
    end
    RX_SYNC = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
